fixed_point_vec_scale: RTL and testbench

FIXED_POINT_VEC_SCALE -- requirements
Module: fixed_point_vec_scale

---
 rtl/fixed_point_vec_scale.sv | 124 ++++++++++++
 tb/tb_fixed_point_vec_scale.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_vec_scale.sv
// Vector-by-scalar fixed-point scaler: one shared signed multiplier walks the vector one element per cycle.
// Define FIXED_POINT_VEC_SCALE_SATURATION_EN to clamp overflowing elements instead of wrapping them.

module fxp_scale_mul #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);
  logic signed [2*WIDTH-1:0] ax, bx, prod, shf;
  logic [WIDTH:0]            hi;

  assign ax   = {{WIDTH{a[WIDTH-1]}}, a};
  assign bx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod = ax * bx;
  assign shf  = prod >>> FRAC_BITS;
  // Shifted product fits in WIDTH bits only if every bit above the result sign matches it.
  assign hi   = shf[2*WIDTH-1:WIDTH-1];
  assign ovf  = (|hi) && !(&hi);

`ifdef FIXED_POINT_VEC_SCALE_SATURATION_EN
  always_comb begin
    res = shf[WIDTH-1:0];
    if (ovf) res = shf[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign res = shf[WIDTH-1:0];
`endif
endmodule

module fixed_point_vec_scale #(
  parameter int WIDTH       = 8,
  parameter int FRAC_BITS   = 5,
  parameter int NUM_OUTPUTS = 16
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic [WIDTH-1:0]             SCALAR_IN,
  input  logic [NUM_OUTPUTS*WIDTH-1:0] VALUES_IN,
  input  logic                         VALID_IN,
  output logic                         BUSY_OUT,
  output logic [NUM_OUTPUTS*WIDTH-1:0] VALUES_OUT,
  output logic                         VALID_OUT,
  output logic                         OVERFLOW
);
  localparam int CW = $clog2(NUM_OUTPUTS);

  typedef enum logic {IDLE, MULTIPLY} state_t;

  state_t                              state_q, state_d;
  logic [CW-1:0]                       cnt_q;
  logic [WIDTH-1:0]                    scal_q;
  logic [NUM_OUTPUTS-1:0][WIDTH-1:0]   vals_q, work_q, work_nxt, out_q;
  logic                                vld_q, ovf_q;
  logic                                accept, last;
  logic [WIDTH-1:0]                    mul_res;
  logic                                mul_ovf;

  fxp_scale_mul #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mul (
    .a   (scal_q),
    .b   (vals_q[cnt_q]),
    .res (mul_res),
    .ovf (mul_ovf)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (VALID_IN) begin
        accept  = 1'b1;
        state_d = MULTIPLY;
      end
      MULTIPLY: if (cnt_q == CW'(NUM_OUTPUTS-1)) begin
        last    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion copies the slot set including the result being written this same edge.
  always_comb begin
    work_nxt        = work_q;
    work_nxt[cnt_q] = mul_res;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scal_q  <= '0;
      vals_q  <= '0;
      work_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= last;
      if (accept) begin
        scal_q <= SCALAR_IN;
        vals_q <= VALUES_IN;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end
      if (state_q == MULTIPLY) begin
        work_q <= work_nxt;
        cnt_q  <= last ? '0 : cnt_q + 1'b1;
        if (mul_ovf) ovf_q <= 1'b1;
        if (last)    out_q <= work_nxt;
      end
    end
  end

  assign BUSY_OUT   = (state_q == MULTIPLY);
  assign VALUES_OUT = out_q;
  assign VALID_OUT  = vld_q;
  assign OVERFLOW   = ovf_q;
endmodule

// File: tb/tb_fixed_point_vec_scale.sv
// Directed plus random checks of fixed_point_vec_scale against a plain-integer reference model.
module tb_fixed_point_vec_scale;
  localparam int W  = 8;
  localparam int F  = 5;
  localparam int N  = 16;
  localparam int VW = N*W;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic [W-1:0]  SCALAR_IN = '0;
  logic [VW-1:0] VALUES_IN = '0;
  logic          VALID_IN = 1'b0;
  logic          BUSY_OUT, VALID_OUT, OVERFLOW;
  logic [VW-1:0] VALUES_OUT;

  int n_vec = 0;
  int n_err = 0;

  fixed_point_vec_scale #(.WIDTH(W), .FRAC_BITS(F), .NUM_OUTPUTS(N)) dut (
    .CLK(CLK), .RSTN(RSTN), .SCALAR_IN(SCALAR_IN), .VALUES_IN(VALUES_IN),
    .VALID_IN(VALID_IN), .BUSY_OUT(BUSY_OUT), .VALUES_OUT(VALUES_OUT),
    .VALID_OUT(VALID_OUT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Real-number semantics: floor(s*v / 2^F), then clamp or keep low W bits when out of range.
  function automatic logic [VW-1:0] model(input logic [W-1:0] s, input logic [VW-1:0] v,
                                          output logic ovf);
    logic [VW-1:0] r;
    int a, b, p, q, lo, hi;
    r = '0; ovf = 1'b0;
    lo = -(2**(W-1)); hi = 2**(W-1) - 1;
    for (int i = 0; i < N; i++) begin
      a = $signed(s);
      b = $signed(v[i*W +: W]);
      p = a * b;
      q = (p >= 0) ? p / (2**F) : -((-p + 2**F - 1) / (2**F));
      if (q > hi || q < lo) begin
        ovf = 1'b1;
`ifdef FIXED_POINT_VEC_SCALE_SATURATION_EN
        q = (q > hi) ? hi : lo;
`endif
      end
      r[i*W +: W] = q[W-1:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after an edge; leaves the bench 1 time unit after the capture edge.
  task automatic start(input logic [W-1:0] s, input logic [VW-1:0] v);
    SCALAR_IN = s; VALUES_IN = v; VALID_IN = 1'b1;
    @(posedge CLK); #1;
    VALID_IN = 1'b0;
  endtask

  task automatic wait_done(input int already, input string tag, input logic [VW-1:0] exp_v,
                           input logic exp_o);
    int c;
    bit seen, moved;
    logic [VW-1:0] prev;
    c = already; seen = 0; moved = 0; prev = VALUES_OUT;
    while (c < 40 && !seen) begin
      @(posedge CLK); #1;
      c++;
      if (VALID_OUT) seen = 1;
      else if (VALUES_OUT !== prev) moved = 1;
    end
    chk({tag, " latency"}, VW'(c), VW'(N));
    chk({tag, " stable"}, VW'(moved), '0);
    chk({tag, " values"}, VALUES_OUT, exp_v);
    chk({tag, " overflow"}, VW'(OVERFLOW), VW'(exp_o));
  endtask

  initial begin
    logic [VW-1:0] va, vb, vc, ev;
    logic          eo;
    bit            got_vld;

    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b1;
    chk("reset busy", VW'(BUSY_OUT), '0);
    chk("reset valid", VW'(VALID_OUT), '0);
    chk("reset ovf", VW'(OVERFLOW), '0);
    chk("reset values", VALUES_OUT, '0);

    // Identity: 1.0 * i
    for (int i = 0; i < N; i++) va[i*W +: W] = W'(i);
    start(8'h20, va);
    chk("ident busy", VW'(BUSY_OUT), VW'(1));
    wait_done(0, "ident", va, 1'b0);
    ev = model(8'h20, va, eo);
    chk("ident model", VALUES_OUT, ev);
    @(posedge CLK); #1;
    chk("ident pulse width", VW'(VALID_OUT), '0);

    // -1.0 * 0x40
    for (int i = 0; i < N; i++) va[i*W +: W] = 8'h40;
    for (int i = 0; i < N; i++) vb[i*W +: W] = 8'hC0;
    start(8'hE0, va);
    wait_done(0, "neg", vb, 1'b0);

    // 0.5 with floor behaviour
    for (int i = 0; i < N; i++) va[i*W +: W] = W'(i * 7);
    va[7:0] = 8'h40; va[15:8] = 8'h01; va[23:16] = 8'hFF;
    ev = model(8'h10, va, eo);
    start(8'h10, va);
    wait_done(0, "half", ev, eo);
    chk("half e0", VW'(VALUES_OUT[7:0]), VW'(8'h20));
    chk("half e1", VW'(VALUES_OUT[15:8]), VW'(8'h00));
    chk("half e2", VW'(VALUES_OUT[23:16]), VW'(8'hFF));

    // Overflow on element 3
    for (int i = 0; i < N; i++) va[i*W +: W] = 8'h20;
    va[31:24] = 8'h60;
    for (int i = 0; i < N; i++) vb[i*W +: W] = 8'h60;
`ifdef FIXED_POINT_VEC_SCALE_SATURATION_EN
    vb[31:24] = 8'h7F;
`else
    vb[31:24] = 8'h20;
`endif
    start(8'h60, va);
    wait_done(0, "ovf", vb, 1'b1);
    repeat (3) @(posedge CLK); #1;
    chk("ovf sticky", VW'(OVERFLOW), VW'(1));
    for (int i = 0; i < N; i++) vc[i*W +: W] = 8'h10;
    start(8'h20, vc);
    chk("ovf cleared", VW'(OVERFLOW), '0);
    wait_done(0, "ovf next", vc, 1'b0);

    // Busy: overflowing request issued mid-flight must be ignored
    for (int i = 0; i < N; i++) va[i*W +: W] = W'(3 * i + 1);
    for (int i = 0; i < N; i++) vb[i*W +: W] = 8'h7F;
    ev = model(8'h18, va, eo);
    start(8'h18, va);
    repeat (4) begin @(posedge CLK); #1; end
    SCALAR_IN = 8'h7F; VALUES_IN = vb; VALID_IN = 1'b1;
    @(posedge CLK); #1;
    VALID_IN = 1'b0;
    wait_done(5, "busy", ev, eo);
    // Back-to-back: request presented during the VALID_OUT cycle
    for (int i = 0; i < N; i++) vc[i*W +: W] = W'(8'hF0 + i);
    start(8'hC8, vc);
    chk("b2b single pulse", VW'(VALID_OUT), '0);
    chk("b2b accepted", VW'(BUSY_OUT), VW'(1));
    ev = model(8'hC8, vc, eo);
    wait_done(0, "b2b", ev, eo);

    // Reset at element 8
    start(8'h40, va);
    repeat (7) begin @(posedge CLK); #1; end
    RSTN = 1'b0;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    chk("rst values", VALUES_OUT, '0);
    chk("rst busy", VW'(BUSY_OUT), '0);
    chk("rst ovf", VW'(OVERFLOW), '0);
    got_vld = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      if (VALID_OUT) got_vld = 1;
    end
    chk("rst no pulse", VW'(got_vld), '0);
    ev = model(8'h40, va, eo);
    start(8'h40, va);
    wait_done(0, "after rst", ev, eo);

    // Random requests
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] s;
      s = W'($urandom);
      for (int i = 0; i < N; i++) va[i*W +: W] = W'($urandom);
      ev = model(s, va, eo);
      start(s, va);
      wait_done(0, $sformatf("rand%0d", k), ev, eo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
